// File: rtl/bram2_addr_seq_l9_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : l9_seq_pkg
//  Brief    : Shared constants and state type for the layer-9 BRAM2
//             access sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package l9_seq_pkg;

    // Phase codes presented on the u output
    localparam logic [2:0] U_IDLE = 3'd3;
    localparam logic [2:0] U_FILL = 3'd2;
    localparam logic [2:0] U_CONV = 3'd4;
    localparam logic [2:0] U_WB   = 3'd5;

    // Write-back slot sequence starts at 2 and ends at 1 (mod-8 walk)
    localparam logic [2:0] Z_FIRST = 3'd2;
    localparam logic [2:0] Z_LAST  = 3'd1;

    // Default geometry
    localparam int DEF_XY_MAX = 7;
    localparam int DEF_J_MAX  = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_CONV = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } l9_state_t;

endpackage
`default_nettype wire

// File: rtl/bram2_addr_seq_l9_wrap_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : l9_wrap_cnt
//  Brief    : Enable/clear/load counter that wraps LAST -> FIRST and flags
//             when it sits on LAST. Clear returns to zero (idle value),
//             load returns to FIRST (first value of an active walk).
//  Revision : 1.0  initial release
// ============================================================================
module l9_wrap_cnt #(
    parameter int WIDTH = 4,
    parameter int FIRST = 0,
    parameter int LAST  = 7
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_load,
    input  wire logic             i_en,
    output logic      [WIDTH-1:0] o_cnt,
    output logic                  o_last
);

    localparam logic [WIDTH-1:0] C_FIRST = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] C_LAST  = WIDTH'(LAST);
    localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    // Counter register: clear beats load beats increment; compare-equal wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= C_FIRST;
        end else if (i_en) begin
            if (r_cnt == C_LAST) begin
                r_cnt <= C_FIRST;
            end else begin
                r_cnt <= r_cnt + C_ONE;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/bram2_addr_seq_l9.sv
`default_nettype none
// ============================================================================
//  Module   : bram2_addr_seq_l9
//  Brief    : Layer-9 BRAM2 access sequencer. Walks FILL, CONV and WB
//             phases after start and emits the registered coordinate/phase
//             stream for the combinational BRAM2 address generator.
//             A presented access (addr_valid=1) is always consumed at the
//             next edge; stall suppresses issue of the following access,
//             which stays frozen on the outputs until stall drops.
//  Revision : 1.0  initial release
// ============================================================================
module bram2_addr_seq_l9
    import l9_seq_pkg::*;
#(
    parameter int XY_MAX = DEF_XY_MAX,
    parameter int J_MAX  = DEF_J_MAX
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       start,
    input  wire logic       stall,
    output logic      [3:0] x,
    output logic      [3:0] y,
    output logic      [1:0] L,
    output logic      [1:0] j,
    output logic      [2:0] u,
    output logic      [2:0] z,
    output logic      [3:0] x_Reg5,
    output logic      [3:0] y_Reg5,
    output logic            addr_valid,
    output logic            busy,
    output logic            done
);

    l9_state_t  r_state;
    logic [2:0] r_u;
    logic [2:0] r_z;
    logic       r_addr_valid;
    logic       r_busy;
    logic       r_done;

    logic [3:0] w_x, w_y, w_xr, w_yr;
    logic [1:0] w_l, w_j;
    logic       w_x_last, w_y_last, w_l_last, w_j_last, w_xr_last, w_yr_last;

    logic w_x_en, w_y_en, w_l_en, w_j_en, w_xr_en, w_yr_en;
    logic w_x_clr, w_y_clr, w_l_clr, w_j_clr, w_xr_clr, w_yr_clr;
    logic w_j_load;

    // The access on the outputs is taken at the next edge whenever it is valid
    logic w_adv;
    logic w_z_last;
    logic w_fill_last;
    logic w_conv_last;
    logic w_wb_last;

    assign w_adv       = r_addr_valid;
    assign w_z_last    = (r_z == Z_LAST);
    assign w_fill_last = w_l_last & w_x_last & w_y_last;
    assign w_conv_last = w_fill_last & w_j_last;
    assign w_wb_last   = w_xr_last & w_yr_last & w_z_last;

    // Counter controls: nested walk order per phase, clears at phase exits
    always_comb begin
        w_x_en   = 1'b0;
        w_y_en   = 1'b0;
        w_l_en   = 1'b0;
        w_j_en   = 1'b0;
        w_xr_en  = 1'b0;
        w_yr_en  = 1'b0;
        w_x_clr  = 1'b0;
        w_y_clr  = 1'b0;
        w_l_clr  = 1'b0;
        w_j_clr  = 1'b0;
        w_xr_clr = 1'b0;
        w_yr_clr = 1'b0;
        w_j_load = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_adv) begin
                    if (w_fill_last) begin
                        w_x_clr  = 1'b1;
                        w_y_clr  = 1'b1;
                        w_l_clr  = 1'b1;
                        w_j_load = 1'b1;
                    end else begin
                        w_y_en = 1'b1;
                        w_x_en = w_y_last;
                        w_l_en = w_y_last & w_x_last;
                    end
                end
            end
            S_CONV: begin
                if (w_adv) begin
                    if (w_conv_last) begin
                        w_x_clr = 1'b1;
                        w_y_clr = 1'b1;
                        w_l_clr = 1'b1;
                        w_j_clr = 1'b1;
                    end else begin
                        w_j_en = 1'b1;
                        w_y_en = w_j_last;
                        w_x_en = w_j_last & w_y_last;
                        w_l_en = w_j_last & w_y_last & w_x_last;
                    end
                end
            end
            S_WB: begin
                if (w_adv) begin
                    if (w_wb_last) begin
                        w_xr_clr = 1'b1;
                        w_yr_clr = 1'b1;
                    end else begin
                        w_yr_en = w_z_last;
                        w_xr_en = w_z_last & w_yr_last;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    l9_wrap_cnt #(.WIDTH(4), .FIRST(0), .LAST(XY_MAX)) u_x_cnt (
        .clk(clk), .rst(rst), .i_clr(w_x_clr), .i_load(1'b0), .i_en(w_x_en),
        .o_cnt(w_x), .o_last(w_x_last)
    );

    l9_wrap_cnt #(.WIDTH(4), .FIRST(0), .LAST(XY_MAX)) u_y_cnt (
        .clk(clk), .rst(rst), .i_clr(w_y_clr), .i_load(1'b0), .i_en(w_y_en),
        .o_cnt(w_y), .o_last(w_y_last)
    );

    l9_wrap_cnt #(.WIDTH(2), .FIRST(0), .LAST(3)) u_l_cnt (
        .clk(clk), .rst(rst), .i_clr(w_l_clr), .i_load(1'b0), .i_en(w_l_en),
        .o_cnt(w_l), .o_last(w_l_last)
    );

    l9_wrap_cnt #(.WIDTH(2), .FIRST(1), .LAST(J_MAX)) u_j_cnt (
        .clk(clk), .rst(rst), .i_clr(w_j_clr), .i_load(w_j_load), .i_en(w_j_en),
        .o_cnt(w_j), .o_last(w_j_last)
    );

    l9_wrap_cnt #(.WIDTH(4), .FIRST(0), .LAST(XY_MAX)) u_xr_cnt (
        .clk(clk), .rst(rst), .i_clr(w_xr_clr), .i_load(1'b0), .i_en(w_xr_en),
        .o_cnt(w_xr), .o_last(w_xr_last)
    );

    l9_wrap_cnt #(.WIDTH(4), .FIRST(0), .LAST(XY_MAX)) u_yr_cnt (
        .clk(clk), .rst(rst), .i_clr(w_yr_clr), .i_load(1'b0), .i_en(w_yr_en),
        .o_cnt(w_yr), .o_last(w_yr_last)
    );

    // Phase FSM with registered phase code, flags and write-back slot z
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_u          <= U_IDLE;
            r_z          <= 3'd0;
            r_addr_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_FILL;
                        r_u          <= U_FILL;
                        r_addr_valid <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_FILL: begin
                    r_addr_valid <= ~stall;
                    if (w_adv && w_fill_last) begin
                        r_state <= S_CONV;
                        r_u     <= U_CONV;
                    end
                end
                S_CONV: begin
                    r_addr_valid <= ~stall;
                    if (w_adv && w_conv_last) begin
                        r_state <= S_WB;
                        r_u     <= U_WB;
                        r_z     <= Z_FIRST;
                    end
                end
                S_WB: begin
                    if (w_adv && w_wb_last) begin
                        r_state      <= S_DONE;
                        r_u          <= U_IDLE;
                        r_z          <= 3'd0;
                        r_addr_valid <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_addr_valid <= ~stall;
                        if (w_adv) begin
                            r_z <= r_z + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_u          <= U_IDLE;
                    r_z          <= 3'd0;
                    r_addr_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
        end
    end

    assign x          = w_x;
    assign y          = w_y;
    assign L          = w_l;
    assign j          = w_j;
    assign u          = r_u;
    assign z          = r_z;
    assign x_Reg5     = w_xr;
    assign y_Reg5     = w_yr;
    assign addr_valid = r_addr_valid;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bram2_addr_seq_l9.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram2_addr_seq_l9
//  Brief    : Scoreboard bench for the layer-9 BRAM2 access sequencer.
//             Stimulus pushes the expected access stream; a negedge
//             monitor pops one entry per valid access. Directed spot
//             checks cover reset, phase boundaries, stall and done timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bram2_addr_seq_l9;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stall;
    logic [3:0] x, y, x_Reg5, y_Reg5;
    logic [1:0] L, j;
    logic [2:0] u, z;
    logic       addr_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [2:0] u;
        logic [1:0] l;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] j;
        logic [2:0] z;
        logic [3:0] xr;
        logic [3:0] yr;
    } acc_t;

    acc_t q[$];

    bram2_addr_seq_l9 #(.XY_MAX(7), .J_MAX(3)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .x(x), .y(y), .L(L), .j(j), .u(u), .z(z),
        .x_Reg5(x_Reg5), .y_Reg5(y_Reg5),
        .addr_valid(addr_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid access must match the head of the scoreboard
    always @(negedge clk) begin
        acc_t got;
        acc_t want;
        if (addr_valid === 1'b1) begin
            got = {u, L, x, y, j, z, x_Reg5, y_Reg5};
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got 0x%0h expected no access (cycle %0d)", got, cyc);
            end else begin
                want = q.pop_front();
                chk("sb_access", 32'(got), 32'(want));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected access stream for one full sequence
    task automatic push_seq();
        acc_t a;
        for (int li = 0; li < 4; li++)
            for (int xi = 0; xi < 8; xi++)
                for (int yi = 0; yi < 8; yi++) begin
                    a = '0;
                    a.u = 3'd2; a.l = 2'(li); a.x = 4'(xi); a.y = 4'(yi);
                    q.push_back(a);
                end
        for (int li = 0; li < 4; li++)
            for (int xi = 0; xi < 8; xi++)
                for (int yi = 0; yi < 8; yi++)
                    for (int ji = 1; ji <= 3; ji++) begin
                        a = '0;
                        a.u = 3'd4; a.l = 2'(li); a.x = 4'(xi); a.y = 4'(yi); a.j = 2'(ji);
                        q.push_back(a);
                    end
        for (int xr = 0; xr < 8; xr++)
            for (int yr = 0; yr < 8; yr++)
                for (int k = 0; k < 8; k++) begin
                    a = '0;
                    a.u = 3'd5; a.z = 3'((k + 2) % 8); a.xr = 4'(xr); a.yr = 4'(yr);
                    q.push_back(a);
                end
    endtask

    // One start-to-done run; optional stall window of stall_len cycles from cycle stall_at
    task automatic run_seq(input int stall_at, input int stall_len, input int exp_done);
        int done_at;
        int zt[9] = '{2, 3, 4, 5, 6, 7, 0, 1, 2};
        int cy[4] = '{0, 0, 0, 1};
        int cj[4] = '{1, 2, 3, 1};
        done_at = -1;
        push_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= exp_done + 1; n++) begin
            if (n > 1) tick();
            if (stall_len > 0 && n == stall_at) stall = 1'b1;
            if (stall_len > 0 && n == stall_at + stall_len) stall = 1'b0;
            if (done === 1'b1 && done_at < 0) done_at = n;
            if (stall_len == 0) begin
                if (n == 1)
                    chk("first_fill", 32'({u, L, x, y, addr_valid}), 32'({3'd2, 2'd0, 4'd0, 4'd0, 1'b1}));
                if (n == 256)
                    chk("fill_last", 32'({u, L, x, y}), 32'({3'd2, 2'd3, 4'd7, 4'd7}));
                if (n >= 257 && n <= 260)
                    chk("conv_order", 32'({u, L, x, y, j}),
                        32'({3'd4, 2'd0, 4'd0, 4'(cy[n-257]), 2'(cj[n-257])}));
                if (n == 1024)
                    chk("conv_last", 32'({u, L, x, y, j}), 32'({3'd4, 2'd3, 4'd7, 4'd7, 2'd3}));
                if (n >= 1025 && n <= 1033)
                    chk("wb_z", 32'({u, z, x_Reg5, y_Reg5, addr_valid}),
                        32'({3'd5, 3'(zt[n-1025]), 4'd0, (n == 1033) ? 4'd1 : 4'd0, 1'b1}));
                if (n == 1536)
                    chk("wb_last", 32'({u, x_Reg5, y_Reg5, z, addr_valid}), 32'({3'd5, 4'd7, 4'd7, 3'd1, 1'b1}));
            end else begin
                if (n > stall_at && n <= stall_at + stall_len)
                    chk("stall_frozen", 32'({addr_valid, u, L, x, y}), 32'({1'b0, 3'd2, 2'd0, 4'd2, 4'd5}));
                if (n == stall_at + stall_len + 1)
                    chk("stall_reissue", 32'({addr_valid, u, L, x, y}), 32'({1'b1, 3'd2, 2'd0, 4'd2, 4'd5}));
            end
            if (n == exp_done)
                chk("done_pulse", 32'({done, u, addr_valid, busy}), 32'({1'b1, 3'd3, 1'b0, 1'b1}));
            if (n == exp_done + 1)
                chk("busy_clear", 32'({busy, done, u}), 32'({1'b0, 1'b0, 3'd3}));
        end
        chk("done_cycle", 32'(done_at), 32'(exp_done));
        chk("sb_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_u", 32'(u), 32'd3);
        chk("rst_coords", 32'({x, y, L, j, z, x_Reg5, y_Reg5}), 32'd0);
        chk("rst_flags", 32'({addr_valid, busy, done}), 32'd0);

        // Plain run: done 1537 cycles after the start edge
        run_seq(0, 0, 1537);

        // Stall raised while (0,2,4) is presented; (0,2,5) held five cycles
        run_seq(21, 5, 1542);

        // Reset together with start in the middle of CONV
        push_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (299) tick();
        chk("mid_conv_u", 32'({u, addr_valid, busy}), 32'({3'd4, 1'b1, 1'b1}));
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        q.delete();
        chk("rst_mid_u", 32'(u), 32'd3);
        chk("rst_mid_coords", 32'({x, y, L, j, z, x_Reg5, y_Reg5}), 32'd0);
        chk("rst_mid_flags", 32'({addr_valid, busy, done}), 32'd0);
        seen = 0;
        repeat (20) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("no_done_after_rst", 32'(seen), 32'd0);

        // Restart from FILL after the mid-sequence reset
        run_seq(0, 0, 1537);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bram2_addr_seq_l9.md
Name: bram2_addr_seq_l9

Overview:
Layer-9 BRAM2 access sequencer. It generates the registered coordinate/phase control stream (x, y, L, j, u, z, x_Reg5, y_Reg5) that drives the combinational BRAM2 address generator of layer 9. It walks three phases after each start: fill, convolution read and write-back. It flags which cycles carry a valid access and pulses done at the end.

Parameters:
XY_MAX, 7, last coordinate value for x/y/x_Reg5/y_Reg5 (coordinates 0..XY_MAX, 4-bit ports)
J_MAX, 3, last kernel-row index j in the CONV phase (j runs 1..J_MAX)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin one full sequence; sampled only in IDLE
stall  in  1  freeze all counters while high (active phases only)
x  out  4  row coordinate, FILL/CONV
y  out  4  column coordinate, FILL/CONV
L  out  2  quadrant select, FILL/CONV
j  out  2  kernel row offset, CONV only
u  out  3  phase code
z  out  3  write-back slot, WB only
x_Reg5  out  4  write-back row coordinate
y_Reg5  out  4  write-back column coordinate
addr_valid  out  1  current outputs form a valid BRAM2 access
busy  out  1  high in any non-IDLE state
done  out  1  one-cycle pulse after last WB access

Behaviour:
- Reset: synchronous, active-high, clock is clk. Wins over start and stall.
- Reset values: state IDLE, x=y=x_Reg5=y_Reg5=0, L=0, j=0, z=0, u=3, addr_valid=0, busy=0, done=0.
- All outputs are registered.
- States and phase codes: IDLE (u=3), FILL (u=2), CONV (u=4), WB (u=5), DONE (u=3).
- IDLE: outputs hold their reset values.
  - start=1 at edge k -> FILL at edge k+1.
  - The first valid access is visible in cycle k+1: x=y=L=0, u=2, addr_valid=1.
- FILL (u=2):
  - Nested order L (outer) -> x -> y (fastest), each 0..XY_MAX.
  - j=0 and z=0 throughout.
  - 4*8*8=256 accesses with default parameters.
  - After L=3, x=7, y=7 -> CONV with all counters cleared and j=1.
- CONV (u=4):
  - Order L -> x -> y -> j (fastest); j runs 1..J_MAX and j=0 is never emitted in this phase.
  - 768 accesses with default parameters.
  - After L=3, x=7, y=7, j=3 -> WB.
- WB (u=5):
  - x, y, L and j are forced to 0.
  - Order x_Reg5 -> y_Reg5 -> z (fastest).
  - z follows the fixed sequence 2,3,4,5,6,7,0,1 and then wraps back to 2.
  - 512 accesses.
  - After x_Reg5=7, y_Reg5=7, z=1 -> DONE.
- DONE:
  - Lasts one cycle: done=1, addr_valid=0, busy=1, u=3.
  - Then returns to IDLE.
  - A start asserted during DONE is ignored.
- stall:
  - In FILL, CONV or WB, stall=1 holds every counter and the state, and drives addr_valid=0 for that cycle.
  - The held access is re-issued (addr_valid=1) on the first cycle after stall drops.
  - stall is ignored in IDLE and DONE.
- start while busy: ignored.
- rst mid-sequence: IDLE with reset values at the next edge; no done pulse.
- Counter widths:
  - Coordinate counters are 4 bits and compare-equal to XY_MAX before wrapping to 0; they never pass through values above XY_MAX.
  - The j counter wraps J_MAX -> 1 in CONV.
  - The z wrap 1 -> 2 happens only in WB.
- With no stall, 1536 valid cycles follow start, and done is high in cycle 1537 after the start edge.

Decomposition:
- Package l9_seq_pkg holds:
  - phase codes U_IDLE=3, U_FILL=2, U_CONV=4, U_WB=5;
  - the state enum;
  - the WB z start/end constants (Z_FIRST=2, Z_LAST=1);
  - the default XY_MAX and J_MAX.
- One natural sub-module: l9_wrap_cnt, a parameterised enable/clear counter with programmable first/last value and wrap flag.
  - Instantiated for each of x, y, L, j, x_Reg5 and y_Reg5.
  - z uses its own 3-bit increment-mod-8 logic, started at 2.

Test Plan:
- Reset then idle 10 cycles -> u=3, all coordinates 0, addr_valid=0, busy=0, done=0.
- start pulse -> next cycle u=2, L=x=y=0, addr_valid=1; cycle 256 shows L=3, x=7, y=7; cycle 257 shows u=4, j=1, L=x=y=0.
- CONV ordering -> first four CONV cycles show (y,j) = (0,1), (0,2), (0,3), (1,1); j never 0 while u=4; last CONV cycle shows L=3, x=7, y=7, j=3.
- WB ordering -> first 9 WB cycles show z = 2,3,4,5,6,7,0,1,2 with y_Reg5 stepping 0 -> 1 at the ninth; done=1 exactly at cycle 1537 with u=3 and addr_valid=0; busy=0 at cycle 1538.
- stall held 5 cycles mid-FILL at x=2, y=5 -> addr_valid=0 for 5 cycles, outputs frozen, then x=2, y=5 re-issued with addr_valid=1; done is delayed by exactly 5 cycles.
- rst asserted during CONV together with start -> next cycle reset values, no done; a later start restarts at FILL with L=x=y=0.
